// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the external interrupt controller.
//   irq_state_t      - request FSM states (IDLE, REQ, HOLD)
//   IRQ_NUM_SRC_DEF  - default number of interrupt source lines
//   IRQ_CNT_W        - width of the post-acknowledge holdoff counter
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_t;

    localparam int IRQ_NUM_SRC_DEF = 4;
    localparam int IRQ_CNT_W       = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req [NUM_SRC]  in  - request vector
//   any            out - at least one request bit set
//   idx [ID_W]     out - index of the lowest set bit (0 when none)
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: external interrupt controller driving the core's ExtIRQ /
// ExtIAck handshake. Rising edges on irq_src are latched as pending; the
// lowest-index eligible pending source is requested and held until the core
// acknowledges, followed by a HOLDOFF-cycle quiet period.
// Optional feature macro: IRQ_MASK_EN (adds a per-source enable mask).
// Ports:
//   clk          in  - clock, rising edge
//   reset        in  - synchronous, active-low reset
//   irq_src      in  - peripheral interrupt lines (rising edge = event)
//   ExtIAck      in  - acknowledge from the core, honoured only in REQ
//   ExtIRQ       out - registered interrupt request to the core
//   irq_id       out - requested source index while ExtIRQ=1, else 0
//   irq_pending  out - pending register
//   mask_we      in  - mask write strobe            (IRQ_MASK_EN only)
//   mask_wdata   in  - new mask, 1 = enabled        (IRQ_MASK_EN only)
//   irq_mask     out - current mask                 (IRQ_MASK_EN only)
module ext_irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int HOLDOFF = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               ExtIAck,
    output logic               ExtIRQ,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] irq_pending
`ifdef IRQ_MASK_EN
    ,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] irq_mask
`endif
);

    irq_state_t            state_q, state_d;
    logic [NUM_SRC-1:0]    src_q, src_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [IRQ_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  req_q, req_d;

    logic [NUM_SRC-1:0]    event_vec;
    logic [NUM_SRC-1:0]    clr_vec;
    logic [NUM_SRC-1:0]    eligible;
    logic                  enc_any;
    logic [ID_W-1:0]       enc_idx;
    logic                  ack_ok;

`ifdef IRQ_MASK_EN
    logic [NUM_SRC-1:0]    mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (mask_we) mask_d = mask_wdata;
    end

    assign eligible = pending_q & mask_q;
    assign irq_mask = mask_q;
`else
    assign eligible = pending_q;
`endif

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req (eligible),
        .any (enc_any),
        .idx (enc_idx)
    );

    assign event_vec = irq_src & ~src_q;
    assign ack_ok    = (state_q == REQ) && ExtIAck;
    assign clr_vec   = ack_ok ? (NUM_SRC'(1) << id_q) : '0;

    always_comb begin
        src_d = irq_src;
        // OR-ing the event last lets a same-cycle set win over the clear.
        pending_d = (pending_q & ~clr_vec) | event_vec;
    end

    // Request FSM: next state, latched id and holdoff counter.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    id_d    = enc_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                // id stays frozen here: no preemption, no withdrawal.
                if (ExtIAck) begin
                    id_d    = '0;
                    cnt_d   = IRQ_CNT_W'(HOLDOFF - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - IRQ_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
                cnt_d   = '0;
            end
        endcase
        // ExtIRQ gets its own flop so the output never decodes state bits.
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
`ifdef IRQ_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
`ifdef IRQ_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign ExtIRQ      = req_q;
    assign irq_id      = id_q;
    assign irq_pending = pending_q;

endmodule
